adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined WIDTH-bit ripple adder built from 1-bit full-adder cells.
- Operand is split into STAGES equal slices; one slice is added per clock and the carry is registered between slices.
- Valid/ready handshake on input and output with full backpressure; throughput one operation per cycle.
- Serves as the arithmetic datapath element for wider operands in the ALU.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of slices; range 1..WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  a/b/cin hold a valid operation.
- in_ready  output  1  adder accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  sum/cout/ovf hold a valid result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset: all stage valid bits, sum, cout, ovf and out_valid clear to 0 immediately on rst_n low, independent of clk.
  - in_ready is 1 while rst_n is high and the pipeline is empty.
  - Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Slice size: SL = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SL +: SL] of the skewed operands plus the carry registered from stage k-1. Stage 0 uses cin.
- Skew registers: unconsumed upper operand slices and already-computed lower sum slices travel with the operation, so the final stage presents a fully aligned sum.
- Advance: adv = !out_valid | out_ready. This is a global enable; all stage registers load only when adv=1.
- in_ready = adv, combinational. An operation is accepted when in_valid & in_ready.
- A bubble (stage valid=0) moves through the pipeline like data. Bubbles are not compressed.
- Latency: exactly STAGES cycles from acceptance to out_valid=1, with no stall.
  - STAGES=1 gives a single registered ripple adder with 1-cycle latency.
- Stall: out_valid=1 & out_ready=0 freezes every register. sum/cout/ovf stay stable until the handshake completes.
- Simultaneous out handshake and in acceptance in the same cycle: both happen and the pipeline shifts. Back-to-back throughput is 1/cycle.
- out_valid deasserts only after a completed handshake with no valid operation behind it.
- in_valid is ignored when in_ready=0. The upstream must hold its operands.
- Overflow: ovf is computed in the last stage from that stage's MSB carries.

Optional Feature:
- Macro: ADDER_PIPE_SUB_EN.
- When defined:
  - Adds port sub (input, 1 bit), sampled with a/b at acceptance and carried down the pipeline.
  - sub=1 computes a - b - cin: internal b' = ~b and carry-in' = ~cin.
  - cout=1 means no borrow; ovf is signed overflow of the subtraction.
  - sub=0 behaves identically to the add-only build.
- When undefined: no sub port, add only, no extra registers.

Decomposition:
- Package adder_pkg: the WIDTH/STAGES legality check constant, the SL function, and the operation struct/typedef (operands, carry, valid, sub flag).
- Sub-module adder_slice: combinational SL-bit ripple adder made of 1-bit full-adder cells.
  - Inputs: a, b, cin. Outputs: sum, cout, and carry into its MSB (for ovf).
  - One adder_slice is instantiated per stage.
- Pipeline registers and handshake logic live in adder_pipe.

Test Plan:
- Defaults, out_ready=1: a=0xFFFFFFFF, b=0x1, cin=0 -> after 4 cycles out_valid=1, sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
- 16 back-to-back operations with in_valid=1 and out_ready=1 -> 16 consecutive out_valid cycles starting at cycle 4, in order, in_ready never 0.
- Hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0; sum/cout/ovf frozen. Release -> no loss or duplication, order preserved.
- Assert rst_n=0 asynchronously between edges with 3 operations in flight -> out_valid=0 immediately. After release, the first new operation appears 4 cycles after acceptance with no stale data.
- ADDER_PIPE_SUB_EN, sub=1: a=0x5, b=0x7, cin=0 -> sum=0xFFFFFFFE, cout=0. a=0x80000000, b=0x1 -> sum=0x7FFFFFFF, ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared helpers for adder_pipe: configuration legality, slice width and per-stage control word.
// The sub flag exists only when ADDER_PIPE_SUB_EN is defined.
package adder_pkg;

    function automatic bit cfg_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Control word that travels with each operation; operands/sum ride in parallel arrays.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef ADDER_PIPE_SUB_EN
        logic sub;
`endif
    } op_ctl_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple adder from 1-bit full-adder cells; zero latency.
// Also exposes the carry into its MSB so the caller can form signed overflow.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit ripple adder, one SL-bit slice per stage; optional subtract via ADDER_PIPE_SUB_EN.
// Latency: STAGES cycles from acceptance to out_valid; throughput one op per cycle.
// Backpressure: global advance = !out_valid | out_ready freezes every register; in_ready = advance.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam bit CFG_OK = cfg_legal(WIDTH, STAGES);
    localparam int SL     = slice_w(WIDTH, STAGES);

    if (!CFG_OK) begin : g_cfg_check
        $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic adv;

    // Operands are shifted down by SL each stage, so every stage consumes bits [SL-1:0].
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    op_ctl_t          ctl_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] opa_d [STAGES];
    logic [WIDTH-1:0] opb_d [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    op_ctl_t          ctl_d [STAGES];
    logic             ovf_d;

    logic [SL-1:0] sl_a  [STAGES];
    logic [SL-1:0] sl_b  [STAGES];
    logic [SL-1:0] sl_s  [STAGES];
    logic          sl_ci [STAGES];
    logic          sl_co [STAGES];
    logic          sl_cm [STAGES];

    assign adv      = !ctl_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_vld;
        logic             src_c;
        logic [WIDTH-1:0] nsum;
        op_ctl_t          nctl;
`ifdef ADDER_PIPE_SUB_EN
        logic             src_sub;
`endif

        if (k == 0) begin : g_head
            assign src_a   = a;
            assign src_b   = b;
            assign src_s   = '0;
            assign src_vld = in_valid;
`ifdef ADDER_PIPE_SUB_EN
            // a - b - cin == a + ~b + ~cin
            assign src_sub = sub;
            assign src_c   = cin ^ sub;
`else
            assign src_c   = cin;
`endif
        end else begin : g_body
            assign src_a   = opa_q[k-1];
            assign src_b   = opb_q[k-1];
            assign src_s   = sum_q[k-1];
            assign src_vld = ctl_q[k-1].valid;
            assign src_c   = ctl_q[k-1].carry;
`ifdef ADDER_PIPE_SUB_EN
            assign src_sub = ctl_q[k-1].sub;
`endif
        end

        assign sl_a[k]  = src_a[SL-1:0];
        assign sl_ci[k] = src_c;
`ifdef ADDER_PIPE_SUB_EN
        assign sl_b[k]  = src_b[SL-1:0] ^ {SL{src_sub}};
`else
        assign sl_b[k]  = src_b[SL-1:0];
`endif

        adder_slice #(.W(SL)) u_slice (
            .a    (sl_a[k]),
            .b    (sl_b[k]),
            .cin  (sl_ci[k]),
            .sum  (sl_s[k]),
            .cout (sl_co[k]),
            .cmsb (sl_cm[k])
        );

        // New slice enters at the top; after STAGES shifts the sum is aligned.
        always_comb begin
            nsum                = src_s >> SL;
            nsum[WIDTH-1 -: SL] = sl_s[k];
        end

        always_comb begin
            nctl       = '0;
            nctl.valid = src_vld;
            nctl.carry = sl_co[k];
`ifdef ADDER_PIPE_SUB_EN
            nctl.sub   = src_sub;
`endif
        end

        assign opa_d[k] = src_a >> SL;
        assign opb_d[k] = src_b >> SL;
        assign sum_d[k] = nsum;
        assign ctl_d[k] = nctl;
    end

    assign ovf_d = sl_cm[STAGES-1] ^ sl_co[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
                ctl_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
                ctl_q[k] <= ctl_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign sum       = sum_q[STAGES-1];
    assign cout      = ctl_q[STAGES-1].carry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (defaults WIDTH=32, STAGES=4): directed vectors, latency, back-to-back,
// stall, async reset and randomized handshakes against an arithmetic reference model.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: {ovf, cout, sum} from plain 33-bit arithmetic.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic s);
        logic [31:0] yy;
        logic [32:0] full;
        logic        v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, c ^ s};
        v    = (x[31] == yy[31]) && (full[31] != x[31]);
        return {v, full[32], full[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: push on acceptance, compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                chk("out_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("out_data", {ovf, cout, sum}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(a, b, cin, sub));
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
        int n;
        a = x; b = y; cin = c; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_single(input logic [31:0] x, input logic [31:0] y, input logic c,
                              input logic [31:0] es, input logic ec, input logic eo);
        int n;
        send(x, y, c);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 4);
        chk("vec_sum", sum, es);
        chk("vec_cout", cout, ec);
        chk("vec_ovf", ovf, eo);
    endtask

    initial begin
        int base;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;

        run_single(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_single(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_single(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

`ifdef ADDER_PIPE_SUB_EN
        sub = 1'b1;
        run_single(32'h5, 32'h7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_single(32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        // Back-to-back: 16 ops, first result in cycle 4, results on 16 consecutive cycles.
        @(posedge clk); #1;
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1);
            chk("b2b_out_valid", out_valid, 64'(i >= 4));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("b2b_tail_valid", out_valid, 64'(j <= 3));
        end
        chk("b2b_count", n_out - base, 16);

        // Stall: fill pipeline with out_ready low, hold for 5 cycles, then release.
        @(posedge clk); #1;
        base = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_frozen", {ovf, cout, sum}, exp_q[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_drain_q", exp_q.size(), 0);
        chk("stall_count", n_out - base, 5);

        // Async reset with operations in flight.
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0);
        @(posedge clk); #1;
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_flags", {cout, ovf}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_single(32'hA5A5_0F0F, 32'h0101_F0F1, 1'b1, 32'hA6A7_0001, 1'b0, 1'b0);

        // Randomized handshakes; upstream holds operands while stalled.
        acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                cin = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("random_drain_q", exp_q.size(), 0);
        chk("random_idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
